instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch front end that sits between the program counter register and instruction memory. It takes the current PC, issues a req/ack read to a variable-latency instruction memory, and pushes each returned instruction with its PC into a 2-entry buffer for decode. It drives the program counter's `hold` and `in_PC` inputs, so the PC advances only when a fetch completes or a redirect arrives.

## Interface
- `ADDR_W`, 16, address/PC width
- `INSTR_W`, 16, instruction width
- `PC_STEP`, 2, byte increment per sequential instruction

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; synchronous, active-low (asserted when 0, sampled on `clk` rising edge)
- `pc_in`  in  ADDR_W  current PC, from the program counter's `out_PC`
- `pc_hold`  out  1  to the program counter's `hold`; 1 = keep the current PC
- `pc_next`  out  ADDR_W  to the program counter's `in_PC`
- `redirect_valid`  in  1  branch/jump taken; flush and restart fetch
- `redirect_addr`  in  ADDR_W  redirect target
- `mem_req`  out  1  instruction memory read request
- `mem_addr`  out  ADDR_W  read address
- `mem_ack`  in  1  read data valid this cycle
- `mem_rdata`  in  INSTR_W  instruction word
- `instr_valid`  out  1  buffer head valid
- `instr`  out  INSTR_W  head instruction
- `instr_pc`  out  ADDR_W  PC of the head instruction
- `instr_ready`  in  1  decode consumes the head when `instr_valid & instr_ready`

## Operation
- FSM states are IDLE, WAIT and DISCARD. `can_issue` = (buffer count < 2) & !`redirect_valid`.
- IDLE:
  - If `can_issue`, drive `mem_req`=1 and `mem_addr`=`pc_in` combinationally, and latch `req_addr`=`pc_in`.
  - If `mem_ack` arrives in the same cycle, complete the fetch and stay in IDLE. Otherwise go to WAIT.
- WAIT:
  - Hold `mem_req`=1 and `mem_addr`=`req_addr` until `mem_ack`. Both stay stable under every condition.
  - On `mem_ack` without a redirect, complete the fetch and go to IDLE.
  - On `redirect_valid` without `mem_ack`, go to DISCARD.
  - On `redirect_valid` with `mem_ack`, drop the data and go to IDLE.
- DISCARD: hold `mem_req`/`mem_addr` as in WAIT. On `mem_ack`, drop the data and go to IDLE. No push.
- Completing a fetch means: push {`mem_rdata`, `req_addr`} into the buffer (in IDLE, `pc_in` is pushed), and pulse `advance`=1 for that cycle.
- `pc_hold` = !(`advance` | `redirect_valid`).
- `pc_next` = `redirect_valid` ? `redirect_addr` : `pc_in` + `PC_STEP`, truncated to ADDR_W. `16'hFFFE` + 2 wraps to `16'h0000`.
- Redirect flushes the buffer in the same cycle. The flush has priority over a push or pop that cycle.
- Buffer:
  - FIFO, 2 entries; `instr_valid` = count != 0.
  - Push and pop in the same cycle leave the count unchanged.
  - Overflow is structurally impossible, because an issue requires count < 2 and only one request is ever outstanding.
  - Pop when empty is ignored.

## Timing
- Reset (while `rst`=0 at the edge): state to IDLE, buffer empty, `req_addr`=0.
- Outputs in the cycle after reset: `mem_req`=0, `instr_valid`=0, `pc_hold`=1. While `rst` is low, `mem_req` is forced to 0 and `pc_hold` to 1.
- Reset mid-transaction abandons the outstanding request. Memory tolerates a dropped request.
- With zero-wait memory (ack in the request cycle) throughput is 1 instruction/cycle. The pushed instruction is visible on `instr_valid` the next cycle.
- With N-cycle ack latency, throughput is 1 instruction per N+1 cycles.
- The PC register updates at the edge that ends an `advance`/redirect cycle. The new `pc_in` is used for the issue in the following cycle.
- `mem_req` is never deasserted before `mem_ack` once asserted, including across a redirect.

## Structure
- Package `fetch_pkg` holds:
  - the `fetch_state_t` enum (IDLE, WAIT, DISCARD);
  - the ADDR_W/INSTR_W/PC_STEP defaults;
  - the `fetch_entry_t` struct {instr, pc}.
- Sub-module `fetch_fifo`: a parameterised 2-entry FIFO with push/pop/flush, count, and head outputs.
- The top level contains the FSM, `req_addr`, and the next-PC logic.

## Test plan
- **Zero-wait stream:** reset, `pc_in`=0x0000, `mem_ack` tied 1, `instr_ready`=1.
  - `pc_next`=0x0002 with `pc_hold`=0 every cycle.
  - Decode sees instr_pc 0x0000, 0x0002, 0x0004 on consecutive cycles.
- **3-cycle latency:** `pc_in`=0x0010, ack 3 cycles after req.
  - `mem_req` stays high with `mem_addr`=0x0010 for 4 cycles and `pc_hold`=1 until the ack cycle.
  - Buffer receives {rdata, 0x0010}.
- **Backpressure:** `instr_ready`=0, zero-wait memory.
  - Exactly 2 entries are fetched, then `mem_req`=0 and `pc_hold`=1 indefinitely.
  - One pop triggers the next fetch the following cycle.
- **Redirect during WAIT:** redirect to 0x0100 one cycle after a req to 0x0020.
  - `pc_next`=0x0100 and the buffer is flushed.
  - `mem_req` stays high at 0x0020 until ack, then the data is dropped.
  - The next req is to 0x0100.
- **Wrap and simultaneous events:**
  - `pc_in`=0xFFFE fetch gives `pc_next`=0x0000.
  - `redirect_valid` and `mem_ack` in the same IDLE cycle: no push, state stays IDLE, `pc_next`=`redirect_addr`.
- **Reset mid-WAIT:** `rst`=0 for one cycle, giving `mem_req`=0 and `instr_valid`=0 the next cycle, then a clean restart.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
// Holds the fetch FSM states and the buffered instruction entry.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;
    localparam int PC_STEP_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO between fetch and decode.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     push_data,
    input  logic       pop,
    input  logic       flush,
    output logic [1:0] count,
    output logic       head_valid,
    output entry_t     head_data
);

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push;
    logic       do_pop;

    // Next pointers, count and storage; pops on empty are ignored.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != 2'd2);
        do_pop   = pop && (count_q != 2'd0);
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: issues one outstanding memory read at a time,
// buffers returned words for decode and steers the PC register.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_hold,
    output logic [ADDR_W-1:0]  pc_next,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              can_issue;
    logic              push;
    logic              advance;
    logic [ADDR_W-1:0] push_pc;
    logic [1:0]        count;
    entry_t            push_data;
    entry_t            head_data;

    // Request FSM: issue, wait for ack, or drain a flushed request.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        mem_req    = 1'b0;
        mem_addr   = req_addr_q;
        push       = 1'b0;
        advance    = 1'b0;
        push_pc    = req_addr_q;
        can_issue  = (count != 2'd2) && !redirect_valid;
        unique case (state_q)
            IDLE: begin
                if (can_issue) begin
                    mem_req    = 1'b1;
                    mem_addr   = pc_in;
                    req_addr_d = pc_in;
                    if (mem_ack) begin
                        push    = 1'b1;
                        advance = 1'b1;
                        push_pc = pc_in;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                if (mem_ack && !redirect_valid) begin
                    push    = 1'b1;
                    advance = 1'b1;
                    state_d = IDLE;
                end else if (mem_ack) begin
                    state_d = IDLE;
                end else if (redirect_valid) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!rst) begin
            mem_req    = 1'b0;
            push       = 1'b0;
            advance    = 1'b0;
            state_d    = IDLE;
            req_addr_d = '0;
        end
    end

    // FSM state and outstanding request address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign push_data = '{instr: mem_rdata, pc: push_pc};

    fetch_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (instr_ready),
        .flush      (redirect_valid),
        .count      (count),
        .head_valid (instr_valid),
        .head_data  (head_data)
    );

    assign instr    = head_data.instr;
    assign instr_pc = head_data.pc;

    assign pc_hold = !rst || !(advance || redirect_valid);
    assign pc_next = redirect_valid ? redirect_addr
                                    : pc_in + ADDR_W'(PC_STEP);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small PC register model.
// Memory returns addr ^ 16'hA5A5 as the instruction word.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_reg;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        pc_hold;
    logic [15:0] pc_next;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr ^ 16'hA5A5;

    always @(posedge clk) begin
        if (pc_load) pc_reg <= pc_load_val;
        else if (!pc_hold) pc_reg <= pc_next;
    end

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_reg),
        .pc_hold        (pc_hold),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        pc_load = 1'b1;
        pc_load_val = 16'h0000;
        redirect_valid = 1'b0;
        redirect_addr = 16'h0000;
        mem_ack = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_hold", 32'(pc_hold), 32'h1);
        chk("rst_valid", 32'(instr_valid), 32'h0);

        // zero-wait stream from 0x0000
        rst = 1'b1; pc_load = 1'b0; mem_ack = 1'b1; instr_ready = 1'b1;
        #1;
        chk("zw_req", 32'(mem_req), 32'h1);
        chk("zw_addr", 32'(mem_addr), 32'h0000);
        chk("zw_next0", 32'(pc_next), 32'h0002);
        chk("zw_hold0", 32'(pc_hold), 32'h0);
        chk("zw_valid0", 32'(instr_valid), 32'h0);
        tick(); #1;
        chk("zw_ipc0", 32'(instr_pc), 32'h0000);
        chk("zw_ins0", 32'(instr), 32'hA5A5);
        chk("zw_next1", 32'(pc_next), 32'h0004);
        chk("zw_hold1", 32'(pc_hold), 32'h0);
        tick(); #1;
        chk("zw_ipc1", 32'(instr_pc), 32'h0002);
        chk("zw_ins1", 32'(instr), 32'hA5A7);
        chk("zw_next2", 32'(pc_next), 32'h0006);
        tick(); #1;
        chk("zw_ipc2", 32'(instr_pc), 32'h0004);
        chk("zw_ins2", 32'(instr), 32'hA5A1);
        pc_load = 1'b1; pc_load_val = 16'h0010;
        tick();

        // 3-cycle ack latency at 0x0010
        pc_load = 1'b0; mem_ack = 1'b0;
        #1;
        chk("lat_ipc6", 32'(instr_pc), 32'h0006);
        for (int i = 0; i < 3; i++) begin
            chk("lat_req", 32'(mem_req), 32'h1);
            chk("lat_addr", 32'(mem_addr), 32'h0010);
            chk("lat_hold", 32'(pc_hold), 32'h1);
            tick(); #1;
            chk("lat_valid", 32'(instr_valid), 32'h0);
        end
        mem_ack = 1'b1;
        #1;
        chk("lat_req_ack", 32'(mem_req), 32'h1);
        chk("lat_addr_ack", 32'(mem_addr), 32'h0010);
        chk("lat_hold_ack", 32'(pc_hold), 32'h0);
        chk("lat_next", 32'(pc_next), 32'h0012);
        tick();

        // backpressure: fill both entries
        instr_ready = 1'b0;
        #1;
        chk("bp_ipc", 32'(instr_pc), 32'h0010);
        chk("bp_ins", 32'(instr), 32'hA5B5);
        chk("bp_req1", 32'(mem_req), 32'h1);
        chk("bp_addr1", 32'(mem_addr), 32'h0012);
        tick(); #1;
        chk("bp_req_full", 32'(mem_req), 32'h0);
        chk("bp_hold_full", 32'(pc_hold), 32'h1);
        tick();
        instr_ready = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0020;
        #1;
        chk("bp_req_full2", 32'(mem_req), 32'h0);
        chk("bp_hold_full2", 32'(pc_hold), 32'h1);
        chk("bp_head", 32'(instr_pc), 32'h0010);
        tick();

        // one pop frees a slot: request to 0x0020, then redirect
        pc_load = 1'b0; instr_ready = 1'b0; mem_ack = 1'b0;
        #1;
        chk("bp_head2", 32'(instr_pc), 32'h0012);
        chk("bp_req_again", 32'(mem_req), 32'h1);
        chk("bp_addr_again", 32'(mem_addr), 32'h0020);
        tick();
        redirect_valid = 1'b1; redirect_addr = 16'h0100;
        #1;
        chk("rd_next", 32'(pc_next), 32'h0100);
        chk("rd_hold", 32'(pc_hold), 32'h0);
        chk("rd_req", 32'(mem_req), 32'h1);
        chk("rd_addr", 32'(mem_addr), 32'h0020);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rd_flushed", 32'(instr_valid), 32'h0);
        chk("rd_req_dis", 32'(mem_req), 32'h1);
        chk("rd_addr_dis", 32'(mem_addr), 32'h0020);
        chk("rd_hold_dis", 32'(pc_hold), 32'h1);
        tick();
        mem_ack = 1'b1;
        #1;
        chk("rd_req_ack", 32'(mem_req), 32'h1);
        chk("rd_addr_ack", 32'(mem_addr), 32'h0020);
        chk("rd_hold_ack", 32'(pc_hold), 32'h1);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("rd_dropped", 32'(instr_valid), 32'h0);
        chk("rd_new_req", 32'(mem_req), 32'h1);
        chk("rd_new_addr", 32'(mem_addr), 32'h0100);
        tick();
        mem_ack = 1'b1;
        #1;
        chk("rd_w_next", 32'(pc_next), 32'h0102);
        chk("rd_w_hold", 32'(pc_hold), 32'h0);
        tick();

        // redirect and ack together in IDLE, target 0xFFFE
        redirect_valid = 1'b1; redirect_addr = 16'hFFFE; instr_ready = 1'b1;
        #1;
        chk("sim_valid", 32'(instr_valid), 32'h1);
        chk("sim_req", 32'(mem_req), 32'h0);
        chk("sim_next", 32'(pc_next), 32'hFFFE);
        chk("sim_hold", 32'(pc_hold), 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("sim_nopush", 32'(instr_valid), 32'h0);
        chk("wrap_req", 32'(mem_req), 32'h1);
        chk("wrap_addr", 32'(mem_addr), 32'hFFFE);
        chk("wrap_next", 32'(pc_next), 32'h0000);
        chk("wrap_hold", 32'(pc_hold), 32'h0);
        tick();
        mem_ack = 1'b0; pc_load = 1'b1; pc_load_val = 16'h0040;
        #1;
        chk("wrap_ipc", 32'(instr_pc), 32'hFFFE);
        chk("wrap_ins", 32'(instr), 32'h5A5B);
        chk("wrap_req0", 32'(mem_addr), 32'h0000);
        tick();

        // reset while waiting on the request to 0x0000
        pc_load = 1'b0;
        #1;
        chk("mw_addr", 32'(mem_addr), 32'h0000);
        chk("mw_valid", 32'(instr_valid), 32'h0);
        rst = 1'b0;
        #1;
        chk("mw_rst_req", 32'(mem_req), 32'h0);
        chk("mw_rst_hold", 32'(pc_hold), 32'h1);
        tick();
        rst = 1'b1; mem_ack = 1'b1;
        #1;
        chk("mw_valid_after", 32'(instr_valid), 32'h0);
        chk("mw_restart_req", 32'(mem_req), 32'h1);
        chk("mw_restart_addr", 32'(mem_addr), 32'h0040);
        tick();
        mem_ack = 1'b0; instr_ready = 1'b0;
        #1;
        chk("mw_ipc", 32'(instr_pc), 32'h0040);
        chk("mw_ivalid", 32'(instr_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
